// File: rtl/rgb2gray_pkg.sv
// rtl/rgb2gray_pkg.sv - shared state encoding and luma constants for rgb2gray_converter
//
// Contents:
//   state_e    - sweep controller states (IDLE, RUN, DRAIN, DONE)
//   COEF_R/G/B - default Q0.8 luma weights (sum to 256)
//   ROUND_BIAS - half-LSB bias added before the >>8 when rounding is enabled
package rgb2gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int COEF_R     = 77;
  localparam int COEF_G     = 150;
  localparam int COEF_B     = 29;
  localparam int ROUND_BIAS = 128;

endpackage

// File: rtl/rgb2gray_converter_if.sv
// rtl/rgb2gray_converter_if.sv - RGB read port and gray write port bundle
//
// Signals:
//   rd_addr                    shared R/G/B read address (converter -> memories)
//   rdata_r, rdata_g, rdata_b  combinational read data (memories -> converter)
//   wr_y, addr_y, wdata_y      gray memory write port (converter -> memory)
// Modports:
//   master - converter side
//   slave  - memory side
interface rgb2gray_converter_if #(
  parameter int ADDR_W = 16
);

  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rdata_r;
  logic [7:0]        rdata_g;
  logic [7:0]        rdata_b;
  logic              wr_y;
  logic [ADDR_W-1:0] addr_y;
  logic [7:0]        wdata_y;

  modport master (
    output rd_addr,
    input  rdata_r,
    input  rdata_g,
    input  rdata_b,
    output wr_y,
    output addr_y,
    output wdata_y
  );

  modport slave (
    input  rd_addr,
    output rdata_r,
    output rdata_g,
    output rdata_b,
    input  wr_y,
    input  addr_y,
    input  wdata_y
  );

endinterface

// File: rtl/rgb2y_mac.sv
// rtl/rgb2y_mac.sv - two-stage weighted-sum pipeline producing 8-bit luma
//
// Optional feature macro: RGB2GRAY_ROUND_EN (round half up instead of truncating).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid, in_addr   pixel qualifier and address, issued with the read
//   in_r, in_g, in_b    pixel channels read at in_addr
//   out_valid           gray write enable, two cycles after in_valid
//   out_addr            gray write address
//   out_data            luma value, holds its last value while out_valid is low
module rgb2y_mac
  import rgb2gray_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int C_R    = COEF_R,
  parameter int C_G    = COEF_G,
  parameter int C_B    = COEF_B
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_r,
  input  logic [7:0]        in_g,
  input  logic [7:0]        in_b,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data
);

  localparam logic [15:0] CR = 16'(C_R);
  localparam logic [15:0] CG = 16'(C_G);
  localparam logic [15:0] CB = 16'(C_B);

`ifdef RGB2GRAY_ROUND_EN
  localparam logic [15:0] BIAS = 16'(ROUND_BIAS);
`else
  localparam logic [15:0] BIAS = 16'd0;
`endif

  logic [15:0]       prod_r;
  logic [15:0]       prod_g;
  logic [15:0]       prod_b;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;

  // Stage 1: weighted channel products plus address/valid passthrough.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_r   <= '0;
      prod_g   <= '0;
      prod_b   <= '0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else begin
      prod_r   <= CR * {8'd0, in_r};
      prod_g   <= CG * {8'd0, in_g};
      prod_b   <= CB * {8'd0, in_b};
      s1_valid <= in_valid;
      s1_addr  <= in_addr;
    end
  end

  // Stage 2: weights sum to 256, so the 16-bit sum (plus bias) never
  // overflows and the top byte is the final luma with no saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_addr <= s1_addr;
        out_data <= 8'((prod_r + prod_g + prod_b + BIAS) >> 8);
      end
    end
  end

endmodule

// File: rtl/rgb2gray_converter.sv
// rtl/rgb2gray_converter.sv - sweeps R/G/B memories and writes luma to gray memory
//
// Optional feature macro: RGB2GRAY_ROUND_EN (handled inside rgb2y_mac).
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle pulse, only honoured in IDLE
//   width, height  image size, sampled on an accepted start
//   busy           high whenever the controller is not IDLE
//   done           one-cycle completion pulse
//   mem            RGB read port and gray write port (master side)
module rgb2gray_converter
  import rgb2gray_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int C_R    = COEF_R,
  parameter int C_G    = COEF_G,
  parameter int C_B    = COEF_B
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8:0]           width,
  input  logic [7:0]           height,
  output logic                 busy,
  output logic                 done,
  rgb2gray_converter_if.master mem
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]        state;
  logic [16:0]       total;
  logic [16:0]       cnt;
  logic              drain_second;
  logic [16:0]       size_prod;
  logic              in_run;
  logic [ADDR_W-1:0] cnt_addr;

  assign size_prod = {8'd0, width} * {9'd0, height};
  assign in_run    = (state == RUN);
  assign cnt_addr  = ADDR_W'(cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      total        <= '0;
      cnt          <= '0;
      drain_second <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt          <= '0;
          drain_second <= 1'b0;
          if (start) begin
            total <= size_prod;
            state <= (size_prod == 17'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (cnt == total - 17'd1) begin
            state <= DRAIN;
          end else begin
            cnt <= cnt + 17'd1;
          end
        end
        // Two cycles let the last pixel leave the two-stage pipeline.
        DRAIN: begin
          if (drain_second) begin
            state <= DONE;
          end
          drain_second <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign mem.rd_addr = in_run ? cnt_addr : '0;

  rgb2y_mac #(
    .ADDR_W (ADDR_W),
    .C_R    (C_R),
    .C_G    (C_G),
    .C_B    (C_B)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_run),
    .in_addr   (cnt_addr),
    .in_r      (mem.rdata_r),
    .in_g      (mem.rdata_g),
    .in_b      (mem.rdata_b),
    .out_valid (mem.wr_y),
    .out_addr  (mem.addr_y),
    .out_data  (mem.wdata_y)
  );

endmodule

// File: tb/tb_rgb2gray_converter.sv
// tb/tb_rgb2gray_converter.sv - scoreboard bench for rgb2gray_converter
module tb_rgb2gray_converter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] width = '0;
  logic [7:0] height = '0;
  logic       busy;
  logic       done;

  int cyc = 0;
  int pass_n = 0;
  int total_n = 0;
  int wr_count = 0;

  logic [7:0] r_mem [0:1023];
  logic [7:0] g_mem [0:1023];
  logic [7:0] b_mem [0:1023];

  logic [23:0] exp_q [$];

  rgb2gray_converter_if #(.ADDR_W(16)) mem_if ();

  assign mem_if.rdata_r = r_mem[mem_if.rd_addr[9:0]];
  assign mem_if.rdata_g = g_mem[mem_if.rd_addr[9:0]];
  assign mem_if.rdata_b = b_mem[mem_if.rd_addr[9:0]];

  rgb2gray_converter #(.ADDR_W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .width  (width),
    .height (height),
    .busy   (busy),
    .done   (done),
    .mem    (mem_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int luma(input int r, input int g, input int b);
    int s;
    s = 77 * r + 150 * g + 29 * b;
`ifdef RGB2GRAY_ROUND_EN
    s = s + 128;
`endif
    return s / 256;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every gray write must match the next expected entry.
  always @(negedge clk) begin
    if (mem_if.wr_y === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(mem_if.addr_y), -1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write_addr", int'(mem_if.addr_y), int'(e[23:8]));
        check("write_data", int'(mem_if.wdata_y), int'(e[7:0]));
      end
    end
  end

  // mode 0: all white, 1: fixed arithmetic corners, 2: random
  task automatic fill(input int tot, input int mode);
    for (int i = 0; i < tot; i++) begin
      if (mode == 0) begin
        r_mem[i] = 8'd255; g_mem[i] = 8'd255; b_mem[i] = 8'd255;
      end else begin
        r_mem[i] = 8'($urandom_range(0, 255));
        g_mem[i] = 8'($urandom_range(0, 255));
        b_mem[i] = 8'($urandom_range(0, 255));
      end
    end
    if (mode == 1) begin
      r_mem[0] = 8'd100; g_mem[0] = 8'd50; b_mem[0] = 8'd200;
      r_mem[1] = 8'd0;   g_mem[1] = 8'd1;  b_mem[1] = 8'd0;
      r_mem[2] = 8'd0;   g_mem[2] = 8'd0;  b_mem[2] = 8'd5;
    end
    for (int i = 0; i < tot; i++) begin
      exp_q.push_back({16'(i), 8'(luma(int'(r_mem[i]), int'(g_mem[i]), int'(b_mem[i])))});
    end
  endtask

  // Returns at the negedge of the done cycle so a following call starts back-to-back.
  task automatic run_image(input int w, input int h, input int mode, input int ign_at);
    int tot, s, dcyc, busy_n, exp_lat;
    bit got;
    tot = w * h;
    fill(tot, mode);
    wr_count = 0;
    @(negedge clk);
    start = 1'b1; width = 9'(w); height = 8'(h);
    s = cyc;
    got = 0; busy_n = 0; dcyc = -1;
    for (int k = 0; k < tot + 12 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == ign_at) begin
        start = 1'b1; width = 9'(w + 3); height = 8'(h + 1);
      end
      if (busy) busy_n++;
      if (done) begin got = 1; dcyc = cyc; end
    end
    start = 1'b0;
    exp_lat = (tot == 0) ? 1 : tot + 3;
    check("done_seen", int'(got), 1);
    check("done_latency", dcyc - s, exp_lat);
    check("busy_cycles", busy_n, exp_lat);
    check("write_count", wr_count, tot);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic reset_mid_run();
    int done_n;
    fill(24, 2);
    wr_count = 0;
    @(negedge clk);
    start = 1'b1; width = 9'd6; height = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wr_y", int'(mem_if.wr_y), 0);
    check("rst_rd_addr", int'(mem_if.rd_addr), 0);
    check("rst_addr_y", int'(mem_if.addr_y), 0);
    check("rst_wdata_y", int'(mem_if.wdata_y), 0);
    check("writes_before_reset", wr_count, 2);
    reset = 1'b0;
    exp_q.delete();
    done_n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("no_done_after_abort", done_n, 0);
    check("no_write_after_abort", wr_count, 2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_wr_y", int'(mem_if.wr_y), 0);
    check("reset_rd_addr", int'(mem_if.rd_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    run_image(4, 2, 0, -1);
    run_image(3, 1, 1, -1);
    run_image(0, 5, 2, -1);
    for (int n = 0; n < 3; n++) begin
      run_image(int'($urandom_range(1, 20)), int'($urandom_range(1, 10)), 2, -1);
    end
    run_image(5, 3, 2, 4);
    check("idle_rd_addr", int'(mem_if.rd_addr), 0);
    reset_mid_run();
    run_image(7, 3, 2, -1);
    run_image(2, 2, 1, -1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb2gray_converter.md
Name: rgb2gray_converter

Overview:
Downstream stage of the demosaic engine. After demosaic pulses done, this block sweeps the full R, G and B channel memories and computes luma for each pixel as Y = (77R + 150G + 29B) >> 8. It writes Y into a separate gray memory. The top level muxes the R/G/B memory address ports to this block while busy is high.

Parameters:
- ADDR_W, 16, pixel address width for the RGB and gray memories.
- COEF_R, 77, R weight (Q0.8).
- COEF_G, 150, G weight (Q0.8).
- COEF_B, 29, B weight (Q0.8). The three weights must sum to 256.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; connected to demosaic done.
- width  in  9  image width in pixels; sampled on accepted start.
- height  in  8  image height in pixels; sampled on accepted start.
- rd_addr  out  ADDR_W  shared read address for the R/G/B memories.
- rdata_r  in  8  R memory read data, combinational from rd_addr.
- rdata_g  in  8  G memory read data, combinational from rd_addr.
- rdata_b  in  8  B memory read data, combinational from rd_addr.
- wr_y  out  1  gray memory write enable.
- addr_y  out  ADDR_W  gray memory write address.
- wdata_y  out  8  gray pixel value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters and pipeline valids cleared.
- Reset mid-operation: aborts the sweep at the next clk edge. No further writes are issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches width/height and loads total = width*height (17-bit product).
  - Goes to RUN if total != 0. If total == 0, goes to DONE with no writes.
  - start is only sampled in IDLE. Pulses in RUN, DRAIN or DONE are ignored.
- RUN:
  - rd_addr = cnt; cnt increments each cycle starting at 0.
  - Stage-1 valid is asserted for every RUN cycle.
  - When cnt == total-1, goes to DRAIN.
- DRAIN: stays 2 cycles to flush the pipeline, then goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy = (state != IDLE).
- rd_addr outside RUN: held at 0.
- Pipeline, with address issue in cycle t:
  - Edge t: register the three 16-bit products (8b x 8b) and the address.
  - Edge t+1: register the 16-bit sum shifted right by 8 as wdata_y, together with addr_y and wr_y=1.
  - Write is visible in cycle t+2, i.e. latency 2.
- Throughput and timing:
  - One pixel per cycle.
  - Total cycles from start to done = total + 3.
  - The last write occurs in the final DRAIN cycle; done follows one cycle later.
- Arithmetic:
  - The sum needs no saturation: maximum 255*256 = 65280 fits in 16 bits.
  - Result is always <= 255.
  - wdata_y holds its last value when wr_y=0.
- Size limit: total > 2^ADDR_W is unsupported; cnt wraps and behaviour is undefined. The bench must not drive it.
- Writes occur at ascending addresses 0..total-1 with no gaps.

Optional Feature:
- Macro: RGB2GRAY_ROUND_EN.
- Defined: adds 128 before the >>8 (round half up). Maximum sum 65408 still fits in 16 bits.
- Undefined: truncation.
- Latency and cycle count are identical in both cases.

Decomposition:
- Package rgb2gray_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default coefficient constants COEF_R/G/B;
  - ROUND_BIAS = 128.
- One natural sub-module: rgb2y_mac. It is the two-stage multiply/accumulate pipeline with valid and address passthrough. The top level keeps the FSM and counter.

Test Plan:
- Sizing: width=4, height=2, all pixels (255,255,255) -> 8 writes, addr 0..7, wdata_y=255, done exactly 11 cycles after the start cycle.
- Arithmetic: pixel (100,50,200) -> 21000 >> 8 = 82. Pixel (0,1,0) -> 0 truncated, 1 with RGB2GRAY_ROUND_EN. Pixel (0,0,5) -> 0 truncated, 1 rounded.
- Zero-size: width=0, height=5, start -> no wr_y, done pulses in the second cycle after start, busy high for exactly 1 cycle.
- Start ignored: a second start pulse mid-RUN with different width/height -> ignored; write count still matches the first image.
- Reset mid-run: reset asserted after 3 RUN cycles -> next cycle all outputs 0, state IDLE, no further writes, no done. A fresh start then completes normally.
- Back-to-back: start asserted in the cycle after done -> accepted. The second image is converted correctly with addresses restarting at 0.
